// File: rtl/multi_state_monitor_if.sv
// multi_state_monitor_if: monitored inputs, configuration and status outputs of the channel monitor.
interface multi_state_monitor_if #(
    parameter int N_CH  = 4,
    parameter int CMP_W = 4
);
    logic [N_CH-1:0]  i_signal;
    logic [N_CH-1:0]  i_polarity;
    logic [N_CH-1:0]  i_enable;
    logic [CMP_W-1:0] i_compare;
    logic             i_clear;
    logic [N_CH-1:0]  o_valid;
    logic [N_CH-1:0]  o_fault;
    logic             o_any_invalid;

    modport master (
        output i_signal, i_polarity, i_enable, i_compare, i_clear,
        input  o_valid, o_fault, o_any_invalid
    );

    modport slave (
        input  i_signal, i_polarity, i_enable, i_compare, i_clear,
        output o_valid, o_fault, o_any_invalid
    );
endinterface

// File: rtl/multi_state_monitor.sv
// multi_state_monitor: per-channel retriggerable hold-off after a transition into the inactive level,
// with sticky faults and a global summary. Define MULTI_STATE_MONITOR_SYNC_EN to add a 2-flop input synchronizer.
module multi_state_monitor #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CMP_W = 4,
    parameter int SCALE = 10000
) (
    input logic                 i_clk,
    input logic                 i_reset,
    multi_state_monitor_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam int PW = CMP_W + 32;
    localparam logic [PW-1:0] LMAX = {{(PW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [PW-1:0]    prod;
    logic [CNT_W-1:0] load_val;
    logic [N_CH-1:0]  sig;
    logic [N_CH-1:0]  r_buf;
    logic [N_CH-1:0]  inv_edge;
    logic [N_CH-1:0]  r_fault;
    logic [N_CH-1:0]  fault_d;
    logic             r_primed;
    state_t           r_state [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    assign prod     = PW'(bus.i_compare) * PW'(SCALE);
    assign load_val = (prod > LMAX) ? LMAX[CNT_W-1:0] : prod[CNT_W-1:0];

`ifdef MULTI_STATE_MONITOR_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [1:0]      r_prime_cnt;

    // Two-flop synchronizer; priming waits until the synchronizer holds real input data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prime_cnt <= '0;
            r_primed    <= 1'b0;
        end else begin
            r_sync1     <= bus.i_signal;
            r_sync2     <= r_sync1;
            r_prime_cnt <= (r_prime_cnt == 2'd2) ? r_prime_cnt : r_prime_cnt + 2'd1;
            r_primed    <= r_primed | (r_prime_cnt == 2'd2);
        end
    end

    assign sig = r_sync2;
`else
    // Priming: detection stays off for the first edge after reset so r_buf holds real input history.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_primed <= 1'b0;
        else         r_primed <= 1'b1;
    end

    assign sig = bus.i_signal;
`endif

    // Previous-sample buffer; tracks the input every edge, even while a channel is disabled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_buf <= '0;
        else         r_buf <= sig;
    end

    assign inv_edge = {N_CH{r_primed}} & (r_buf ^ sig) & (sig ^ bus.i_polarity);

    // Per-channel state, hold-off counters and sticky faults.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= '{default: IDLE};
            r_cnt   <= '{default: '0};
            r_fault <= '0;
        end else begin
            r_state <= state_d;
            r_cnt   <= cnt_d;
            r_fault <= fault_d;
        end
    end

    // Next state: disable wins, then (re)trigger on an invalid edge, else count down to IDLE.
    always_comb begin
        fault_d = r_fault & ~{N_CH{bus.i_clear}};
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = r_state[c];
            cnt_d[c]   = r_cnt[c];
            if (!bus.i_enable[c]) begin
                state_d[c] = IDLE;
                cnt_d[c]   = '0;
            end else if (inv_edge[c]) begin
                state_d[c] = HOLD;
                cnt_d[c]   = load_val;
                fault_d[c] = 1'b1;
            end else if (r_state[c] == HOLD) begin
                state_d[c] = (r_cnt[c] == '0) ? IDLE : HOLD;
                cnt_d[c]   = (r_cnt[c] == '0) ? r_cnt[c] : r_cnt[c] - CNT_W'(1);
            end
        end
    end

    // Valid is a pure decode of registered state.
    always_comb begin
        bus.o_valid = '1;
        for (int c = 0; c < N_CH; c++) bus.o_valid[c] = (r_state[c] != HOLD);
    end

    assign bus.o_fault       = r_fault;
    assign bus.o_any_invalid = ~&bus.o_valid;
endmodule

// File: tb/tb_multi_state_monitor.sv
// tb_multi_state_monitor: vector table plus corner sequences, expectations queued on drive and checked after the edge.
module tb_multi_state_monitor;
    typedef struct {
        logic [3:0] sig;
        logic [3:0] en;
        logic [3:0] cmp;
        logic       clr;
        logic [3:0] v;
        logic [3:0] f;
    } vec_t;

    typedef struct {
        logic [3:0] v;
        logic [3:0] f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq [$];
    vec_t tbl [17];

    multi_state_monitor_if #(.N_CH(4), .CMP_W(4)) ifa ();
    multi_state_monitor_if #(.N_CH(4), .CMP_W(4)) ifb ();

    multi_state_monitor #(.N_CH(4), .CNT_W(16), .CMP_W(4), .SCALE(4)) dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifa)
    );

    multi_state_monitor #(.N_CH(4), .CNT_W(8), .CMP_W(4), .SCALE(100)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [3:0] sig, input logic [3:0] en, input logic [3:0] cmp,
                        input logic clr, input logic [3:0] v, input logic [3:0] f);
        exp_t e;
        ifa.i_signal  = sig;
        ifa.i_enable  = en;
        ifa.i_compare = cmp;
        ifa.i_clear   = clr;
        e.v = v;
        e.f = f;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({name, " valid"}, 32'(ifa.o_valid), 32'(e.v));
        check({name, " fault"}, 32'(ifa.o_fault), 32'(e.f));
        check({name, " any_invalid"}, 32'(ifa.o_any_invalid), 32'(~&e.v));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  done;
        // polarity: ch0/ch2 valid high, ch1/ch3 valid low; ch1 sits at its inactive level through reset
        tbl[0]  = '{4'b0111, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b0000};
        tbl[1]  = '{4'b0111, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b0000};
        tbl[2]  = '{4'b0110, 4'b1111, 4'd0, 1'b0, 4'b1110, 4'b0001};
        tbl[3]  = '{4'b0110, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b0001};
        tbl[4]  = '{4'b0110, 4'b1111, 4'd0, 1'b1, 4'b1111, 4'b0000};
        tbl[5]  = '{4'b0111, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b0000};
        tbl[6]  = '{4'b1101, 4'b1111, 4'd1, 1'b0, 4'b0111, 4'b1000};
        tbl[7]  = '{4'b1101, 4'b1111, 4'd1, 1'b0, 4'b0111, 4'b1000};
        tbl[8]  = '{4'b1101, 4'b1111, 4'd1, 1'b0, 4'b0111, 4'b1000};
        tbl[9]  = '{4'b1101, 4'b1111, 4'd1, 1'b0, 4'b0111, 4'b1000};
        tbl[10] = '{4'b1101, 4'b1111, 4'd1, 1'b0, 4'b0111, 4'b1000};
        tbl[11] = '{4'b1101, 4'b1111, 4'd1, 1'b0, 4'b1111, 4'b1000};
        tbl[12] = '{4'b1011, 4'b1111, 4'd0, 1'b0, 4'b1001, 4'b1110};
        tbl[13] = '{4'b1011, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b1110};
        tbl[14] = '{4'b1010, 4'b1110, 4'd0, 1'b0, 4'b1111, 4'b1110};
        tbl[15] = '{4'b1010, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b1110};
        tbl[16] = '{4'b1011, 4'b1111, 4'd0, 1'b0, 4'b1111, 4'b1110};

        ifa.i_polarity = 4'b0101;
        ifa.i_signal   = 4'b0111;
        ifa.i_enable   = 4'b1111;
        ifa.i_compare  = 4'd0;
        ifa.i_clear    = 1'b0;
        ifb.i_polarity = 4'b1111;
        ifb.i_signal   = 4'b1111;
        ifb.i_enable   = 4'b1111;
        ifb.i_compare  = 4'd15;
        ifb.i_clear    = 1'b0;

        #12;
        check("reset valid", 32'(ifa.o_valid), 32'hf);
        check("reset fault", 32'(ifa.o_fault), 32'h0);
        check("reset any_invalid", 32'(ifa.o_any_invalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++)
            step($sformatf("row%0d", i), tbl[i].sig, tbl[i].en, tbl[i].cmp, tbl[i].clr, tbl[i].v, tbl[i].f);

        // single edge, L = 3*4 = 12 -> 13 low cycles
        step("a_clear", 4'b1011, 4'b1111, 4'd3, 1'b1, 4'b1111, 4'b0000);
        for (int i = 0; i < 14; i++)
            step($sformatf("a_pulse%0d", i), 4'b1010, 4'b1111, 4'd3, 1'b0,
                 (i <= 12) ? 4'b1110 : 4'b1111, 4'b0001);
        step("a_rearm", 4'b1011, 4'b1111, 4'd3, 1'b0, 4'b1111, 4'b0001);

        // retrigger at k+8 -> low through k+20
        for (int i = 0; i < 22; i++)
            step($sformatf("a_retrig%0d", i), (i >= 4 && i < 8) ? 4'b1011 : 4'b1010, 4'b1111, 4'd3, 1'b0,
                 (i <= 20) ? 4'b1110 : 4'b1111, 4'b0001);

        // enable drop mid-HOLD, and clear colliding with a new fault
        step("b_clear", 4'b1010, 4'b1111, 4'd3, 1'b1, 4'b1111, 4'b0000);
        step("b_prep", 4'b1100, 4'b1111, 4'd3, 1'b0, 4'b1111, 4'b0000);
        step("b_ch1_hold", 4'b1110, 4'b1111, 4'd3, 1'b0, 4'b1101, 4'b0010);
        step("b_drop_clr", 4'b1010, 4'b1101, 4'd3, 1'b1, 4'b1011, 4'b0100);
        step("b_after", 4'b1010, 4'b1101, 4'd3, 1'b0, 4'b1011, 4'b0100);

        // asynchronous reset while ch2 is holding
        #2;
        rst = 1'b1;
        #1;
        check("c_async valid", 32'(ifa.o_valid), 32'hf);
        check("c_async fault", 32'(ifa.o_fault), 32'h0);
        check("c_async any_invalid", 32'(ifa.o_any_invalid), 32'h0);
        ifa.i_enable = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        step("c_prime", 4'b1010, 4'b1111, 4'd3, 1'b0, 4'b1111, 4'b0000);
        step("c_quiet", 4'b1010, 4'b1111, 4'd3, 1'b0, 4'b1111, 4'b0000);
        step("c_rise", 4'b1011, 4'b1111, 4'd3, 1'b0, 4'b1111, 4'b0000);
        step("c_fall", 4'b1010, 4'b1111, 4'd3, 1'b0, 4'b1110, 4'b0001);

        // saturation: 15*100 = 1500 clamps to 255 -> 256 low cycles
        ifb.i_signal = 4'b1110;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!ifb.o_valid[0]) n++;
            else if (n > 0) done = 1'b1;
        end
        check("d_sat_len", 32'(n), 32'd256);
        check("d_sat_fault", 32'(ifb.o_fault), 32'h1);
        check("d_sat_done", 32'(done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_state_monitor.md
Name: multi_state_monitor

Overview:
- N-channel successor to the single-channel state monitor.
- Each channel watches one digital signal for a transition into its inactive level, then drops its valid flag for a programmable hold-off time. The time is measured in clock cycles and is retriggerable.
- Adds per-channel enable, sticky fault latches with clear, a global fault summary, counter saturation and post-reset priming.
- Sits between the top-level input pins and the status outputs of the tile wrapper.

Parameters:
- N_CH, 4, number of monitored channels.
- CNT_W, 16, width of each hold-off down-counter.
- CMP_W, 4, width of the hold-off select input.
- SCALE, 10000, cycles per unit of i_compare; 10000 gives 1 s per unit at 10 kHz.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous reset, active-high.
- i_signal  in  N_CH  monitored signals, one bit per channel.
- i_polarity  in  N_CH  per-channel valid level: 1 means valid when high, 0 means valid when low.
- i_enable  in  N_CH  per-channel monitor enable.
- i_compare  in  CMP_W  hold-off select, shared by all channels.
- i_clear  in  1  synchronous clear of all sticky faults.
- o_valid  out  N_CH  per-channel valid, 1 = channel good.
- o_fault  out  N_CH  per-channel sticky fault latch.
- o_any_invalid  out  1  OR of all ~o_valid bits.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - all channels IDLE, counters 0;
  - r_buf = 0, r_primed = 0;
  - o_valid = all 1s, o_fault = 0, o_any_invalid = 0.
- Hold-off load value: L = min(i_compare * SCALE, 2^CNT_W - 1).
  - Compute the product at CMP_W + 32 bits, then saturate; never truncate.
  - L is sampled at the edge where it is loaded.
- Priming: on the first clock edge after reset release, r_buf loads i_signal and r_primed is set. No edge detection runs on that edge, which blocks a spurious fault when the input is already at its inactive level.
- Invalid edge on channel c: r_primed & (r_buf[c] != i_signal[c]) & (i_signal[c] != i_polarity[c]). r_buf updates every edge.
- Per-channel FSM has two states, IDLE and HOLD.
  - IDLE: on an invalid edge with i_enable[c] = 1, go to HOLD and load counter with L.
  - HOLD, invalid edge: reload L and stay in HOLD (retrigger).
  - HOLD, counter == 0 and no invalid edge: go to IDLE.
  - HOLD, otherwise: decrement counter by 1. The counter never wraps.
- o_valid[c] = (state != HOLD), registered-state decode with no combinational path from i_signal.
  - A single invalid edge sampled at edge k gives o_valid low from k for exactly L+1 cycles.
  - i_compare = 0 gives a 1-cycle low pulse.
- i_enable[c] = 0 forces IDLE with counter 0 at the next edge and suppresses detection. r_buf still tracks the input, so re-enabling does not produce a false edge.
- o_fault[c] sets on the IDLE-to-HOLD transition and on every retrigger. i_clear clears all bits. If set and clear occur on the same edge, set wins.
- o_any_invalid is combinational OR of ~o_valid.
- Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.
- Reset mid-HOLD drops to IDLE immediately (o_valid = 1) and re-primes afterwards.

Optional Feature:
- Macro: MULTI_STATE_MONITOR_SYNC_EN.
- Defined: a 2-flop synchronizer per channel sits in front of edge detection. Its flops are reset to 0, and priming waits for 3 edges after reset release. Every detection is delayed by 2 cycles.
- Undefined: i_signal feeds detection directly (assumed synchronous), with priming as specified above.

Test Plan:
- SCALE=4, i_compare=3 (L=12), ch0 polarity=1, ch0 edge 1→0 at edge k → o_valid[0] low for cycles k..k+12 (13 cycles), o_fault[0]=1, o_any_invalid mirrors it, other channels unaffected.
- Same setup, second 1→0 edge on ch0 at k+8 → counter reloads; o_valid[0] stays low until k+8+12, then returns to 1.
- Polarity=0 channel held at 1 through reset release → no fault and o_valid stays 1. Then a 0→1 edge → HOLD.
- CNT_W=8, SCALE=100, i_compare=15 → L saturates to 255; the low pulse lasts 256 cycles.
- HOLD on ch1 with i_enable[1] dropped → IDLE next edge, o_valid[1]=1. Assert i_clear on the same edge as a new fault on ch2 → o_fault[2] stays 1.
- Assert i_reset asynchronously mid-HOLD (between edges) → o_valid all 1s and o_fault 0 immediately, without waiting for a clock edge.
